mux_nway_pipe: RTL and testbench

//  Parametrised N-way, WIDTH-bit selector with a registered, valid/ready-handshaked output stage.

---
 rtl/mux_nway_pipe_pkg.sv | 14 +
 rtl/mux_nway_pipe_rr_arbiter.sv | 50 +++++
 rtl/mux_nway_pipe.sv | 87 ++++++++
 tb/tb_mux_nway_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_nway_pipe_pkg.sv
// Shared constants and helpers for the N-way pipelined selector.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_nway_pipe_pkg;

  localparam int MODE_SEL = 0;  // explicit select from the control unit
  localparam int MODE_RR  = 1;  // round-robin arbitration among valid inputs

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nway_pipe_rr_arbiter.sv
// Round-robin grant among requesting channels, starting the search at rr_ptr.
// Latency: grant is combinational; rr_ptr moves one past the winner on the cycle it is taken.
// Backpressure: rr_ptr only advances when the caller reports the grant was taken.
module mux_nway_pipe_rr_arbiter
  import mux_nway_pipe_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] rr_ptr;

  // Channel index k positions above ptr, wrapping back to 0.
  function automatic logic [SEL_W-1:0] rot_idx(input logic [SEL_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return SEL_W'(s);
  endfunction

  // Scan from the farthest position back to rr_ptr so the nearest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (req[rot_idx(rr_ptr, k)]) begin
        grant                    = '0;
        grant[rot_idx(rr_ptr, k)] = 1'b1;
        grant_idx                = rot_idx(rr_ptr, k);
      end
    end
  end

  // Move the pointer just past the channel that was served; frozen otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mux_nway_pipe.sv
// N-way WIDTH-bit selector (explicit select or round-robin) feeding one registered output slot.
// Latency: a word accepted in cycle t is on out_data in cycle t+1; one word per cycle sustained.
// Backpressure: in_ready is zero while the slot holds an undrained word or reset is high.
module mux_nway_pipe
  import mux_nway_pipe_pkg::*;
#(
  parameter  int WIDTH  = 5,
  parameter  int NUM_IN = 4,
  parameter  int MODE   = MODE_SEL,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  sel_data;
  logic              free;
  logic              xfer;

  // The slot can take a new word if it is empty or being drained this cycle.
  assign free = !out_valid || out_ready;
  assign xfer = |in_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      mux_nway_pipe_rr_arbiter #(
        .NUM_IN(NUM_IN)
      ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
      );
      logic unused_sel;
      assign unused_sel = ^sel;
    end else begin : g_sel
      // Grant the selected channel if it holds a word; out-of-range selects grant nothing.
      always_comb begin
        grant = '0;
        if (int'(sel) < NUM_IN) grant[sel] = in_valid[sel];
      end
      assign grant_idx = sel;
    end
  endgenerate

  // AND-OR select of the granted channel's word (grant is one-hot or zero).
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Accept the granted word only when the slot is free and reset is released.
  always_comb begin
    in_ready = '0;
    if (!reset) in_ready = grant & {NUM_IN{free}};
  end

  // Output slot: load on transfer (replacing any word drained this cycle), else clear on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nway_pipe.sv
// Bench for mux_nway_pipe: one explicit-select instance and one round-robin instance.
// Latency: outputs compared every cycle against a transaction-level model.
// Backpressure: randomized out_ready; producers hold words until they are taken.
module tb_mux_nway_pipe;
  localparam int W  = 5;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N*W-1:0] idat [2];
  logic [N-1:0]   iv   [2];
  logic [N-1:0]   ir   [2];
  logic [SW-1:0]  sel0, sel1;
  logic [W-1:0]   od   [2];
  logic [SW-1:0]  os   [2];
  logic           ov   [2];
  logic           ordy [2];

  mux_nway_pipe #(.WIDTH(W), .NUM_IN(N), .MODE(0)) dut_sel (
    .clk(clk), .reset(rst), .in_data(idat[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .sel(sel0), .out_data(od[0]), .out_src(os[0]), .out_valid(ov[0]), .out_ready(ordy[0])
  );

  mux_nway_pipe #(.WIDTH(W), .NUM_IN(N), .MODE(1)) dut_rr (
    .clk(clk), .reset(rst), .in_data(idat[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .sel(sel1), .out_data(od[1]), .out_src(os[1]), .out_valid(ov[1]), .out_ready(ordy[1])
  );

  // Model: contents of each output slot, the round-robin position, and words still waiting.
  bit       m_vld [2];
  int       m_dat [2];
  int       m_src [2];
  int       m_ptr;
  bit [N-1:0] pend [2];

  int n_cmp;
  int n_err;

  task automatic cmp(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, got, want, $time);
    end
  endtask

  // Which channel the consumer side will take this cycle, straight from the selection rules.
  function automatic logic [N-1:0] model_ready(input int d);
    logic [N-1:0] g;
    g = '0;
    if (rst || (m_vld[d] && !ordy[d])) return g;
    if (d == 0) begin
      if (int'(sel0) < N && iv[0][sel0]) g[sel0] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (iv[1][c]) begin
          g[c] = 1'b1;
          return g;
        end
      end
    end
    return g;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 0;
      m_dat[d] = 0;
      m_src[d] = 0;
      pend[d]  = '0;
    end
    m_ptr = 0;
  endtask

  task automatic model_update();
    logic [N-1:0] r [2];
    for (int d = 0; d < 2; d++) r[d] = model_ready(d);
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (r[d] != '0) begin
        int idx;
        idx      = onehot_idx(r[d]);
        m_vld[d] = 1;
        m_dat[d] = int'(idat[d][idx*W +: W]);
        m_src[d] = idx;
        if (d == 1) m_ptr = (idx + 1) % N;
      end else if (ordy[d]) begin
        m_vld[d] = 0;
      end
      pend[d] = iv[d] & ~r[d];
    end
  endtask

  // Compare every DUT output against the model (called once per cycle, mid-low-phase).
  task automatic check_all();
    #1;
    if (rst) model_reset();
    for (int d = 0; d < 2; d++) begin
      cmp("in_ready",  d, 32'(ir[d]), 32'(model_ready(d)));
      cmp("out_valid", d, 32'(ov[d]), 32'(m_vld[d]));
      cmp("out_data",  d, 32'(od[d]), m_dat[d]);
      cmp("out_src",   d, 32'(os[d]), m_src[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst  = 1'b1;
    sel0 = '0;
    sel1 = '0;
    for (int d = 0; d < 2; d++) begin
      iv[d]   = '1;
      ordy[d] = 1'b0;
      idat[d] = 20'($urandom);
    end
    @(negedge clk);
    @(negedge clk);

    // Reset with everything valid and no consumer.
    check_all();
    for (int d = 0; d < 2; d++) begin
      cmp("rst_out_valid", d, 32'(ov[d]), 32'd0);
      cmp("rst_out_data",  d, 32'(od[d]), 32'd0);
      cmp("rst_in_ready",  d, 32'(ir[d]), 32'd0);
    end
    rst = 1'b0;
    iv[0] = '0; iv[1] = '0; ordy[0] = 1'b1; ordy[1] = 1'b1;
    check_all();
    tick();

    // Explicit select of channel 2.
    sel0 = 2'd2;
    iv[0] = 4'b0100;
    idat[0][2*W +: W] = 5'h1A;
    check_all();
    cmp("sel_in_ready", 0, 32'(ir[0]), 32'h4);
    tick();
    check_all();
    cmp("sel_out_data",  0, 32'(od[0]), 32'h1A);
    cmp("sel_out_src",   0, 32'(os[0]), 32'd2);
    cmp("sel_out_valid", 0, 32'(ov[0]), 32'd1);

    // Stall three cycles with a new word waiting, then release.
    ordy[0] = 1'b0;
    idat[0][2*W +: W] = 5'h07;
    repeat (3) begin
      check_all();
      cmp("stall_hold_data", 0, 32'(od[0]), 32'h1A);
      cmp("stall_in_ready",  0, 32'(ir[0]), 32'd0);
      tick();
    end
    ordy[0] = 1'b1;
    check_all();
    cmp("release_in_ready", 0, 32'(ir[0]), 32'h4);
    tick();
    check_all();
    cmp("replace_data", 0, 32'(od[0]), 32'h07);
    iv[0] = '0;
    check_all();
    tick();
    check_all();
    cmp("drain_valid", 0, 32'(ov[0]), 32'd0);

    // Round-robin rotation with all channels valid.
    iv[1] = 4'b1111;
    ordy[1] = 1'b1;
    idat[1] = 20'($urandom);
    for (int k = 0; k < 8; k++) begin
      check_all();
      tick();
      cmp("rr_rotate_src", 1, 32'(os[1]), 32'(k % N));
    end

    // Move pointer to 2, then compete channels 1 and 3.
    iv[1] = 4'b0010;
    check_all();
    tick();
    cmp("rr_ch1_src", 1, 32'(os[1]), 32'd1);
    iv[1] = 4'b1010;
    check_all();
    cmp("rr_wrap_ready", 1, 32'(ir[1]), 32'h8);
    tick();
    cmp("rr_wrap_src3", 1, 32'(os[1]), 32'd3);
    check_all();
    cmp("rr_next_ready", 1, 32'(ir[1]), 32'h2);
    tick();
    cmp("rr_next_src1", 1, 32'(os[1]), 32'd1);
    iv[1] = '0;
    check_all();
    tick();

    // Reset while stalled drops the held word immediately.
    iv[1] = 4'b0001;
    ordy[1] = 1'b0;
    check_all();
    tick();
    iv[1] = '0;
    check_all();
    cmp("pre_rst_valid", 1, 32'(ov[1]), 32'd1);
    tick();
    check_all();
    rst = 1'b1;
    check_all();
    cmp("async_rst_drop", 1, 32'(ov[1]), 32'd0);
    tick();
    rst = 1'b0;
    iv[1] = 4'b1111;
    ordy[1] = 1'b1;
    check_all();
    cmp("post_rst_ready", 1, 32'(ir[1]), 32'h1);
    tick();
    cmp("post_rst_src", 1, 32'(os[1]), 32'd0);
    cmp("post_rst_valid", 1, 32'(ov[1]), 32'd1);

    // Randomized traffic; waiting words stay valid and unchanged until taken.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[d][i]) begin
            iv[d][i] = ($urandom_range(0, 99) < 60);
            idat[d][i*W +: W] = W'($urandom);
          end
        end
        ordy[d] = ($urandom_range(0, 99) < 70);
      end
      sel0 = SW'($urandom_range(0, N - 1));
      check_all();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
